// File: rtl/tone_seq_pkg.sv
// rtl/tone_seq_pkg.sv - shared widths, table entry layout and FSM state encoding for the tone sequencer
package tone_seq_pkg;
    localparam int FCW_BITS     = 4;
    localparam int DUR_BITS     = 16;
    localparam int DEPTH        = 8;
    localparam int ADDR_BITS    = 3;
    localparam int GAP_TICKS    = 4;
    localparam int GAP_CNT_BITS = $clog2(GAP_TICKS + 1);

    // Entry layout, LSB first: {last, dur, fcw}
    localparam int ENTRY_BITS = FCW_BITS + DUR_BITS + 1;
    localparam int FCW_LSB    = 0;
    localparam int DUR_LSB    = FCW_BITS;
    localparam int LAST_BIT   = FCW_BITS + DUR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;
endpackage

// File: rtl/tone_seq_table.sv
// rtl/tone_seq_table.sv - DEPTH x ENTRY_BITS tone table, one synchronous write port, asynchronous read
module tone_seq_table
    import tone_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [ENTRY_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [ENTRY_BITS-1:0] rd_data
);
    logic [ENTRY_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/tone_seq_ctrl.sv
// rtl/tone_seq_ctrl.sv - tone table sequencer driving NCO fcw/enable; define TONE_GAP_EN for silent gaps between entries
module tone_seq_ctrl
    import tone_seq_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 stop_in,
    input  logic                 loop_in,
    input  logic                 tick_in,
    input  logic                 cfg_we_in,
    input  logic [ADDR_BITS-1:0] cfg_addr_in,
    input  logic [FCW_BITS-1:0]  cfg_fcw_in,
    input  logic [DUR_BITS-1:0]  cfg_dur_in,
    input  logic                 cfg_last_in,
    output logic [FCW_BITS-1:0]  fcw_out,
    output logic                 nco_en_out,
    output logic                 busy_out,
    output logic [ADDR_BITS-1:0] step_out,
    output logic                 done_out
);
    state_t                  state;
    logic [ADDR_BITS-1:0]    idx;
    logic [DUR_BITS-1:0]     cnt;
    logic [GAP_CNT_BITS-1:0] gap_cnt;
    logic [ENTRY_BITS-1:0]   entry;
    logic [FCW_BITS-1:0]     entry_fcw;
    logic [DUR_BITS-1:0]     entry_dur;
    logic                    entry_last;
    logic                    wr_en;
    logic                    entry_done;
    logic                    table_end;

    // The table is frozen while busy, so entry[idx] stays valid through LOAD and PLAY.
    assign wr_en = cfg_we_in && (state == ST_IDLE);

    tone_seq_table u_table (
        .clk     (clk_in),
        .rst     (rst_in),
        .wr_en   (wr_en),
        .wr_addr (cfg_addr_in),
        .wr_data ({cfg_last_in, cfg_dur_in, cfg_fcw_in}),
        .rd_addr (idx),
        .rd_data (entry)
    );

    assign entry_fcw  = entry[FCW_LSB +: FCW_BITS];
    assign entry_dur  = entry[DUR_LSB +: DUR_BITS];
    assign entry_last = entry[LAST_BIT];

    assign entry_done = ((state == ST_LOAD) && (entry_dur == '0))
                     || ((state == ST_PLAY) && tick_in && (cnt == DUR_BITS'(1)));
    assign table_end  = entry_last || (idx == ADDR_BITS'(DEPTH - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            gap_cnt    <= '0;
            fcw_out    <= '0;
            nco_en_out <= 1'b0;
            busy_out   <= 1'b0;
            step_out   <= '0;
            done_out   <= 1'b0;
        end else if (stop_in) begin
            state      <= ST_IDLE;
            idx        <= '0;
            fcw_out    <= '0;
            nco_en_out <= 1'b0;
            busy_out   <= 1'b0;
            step_out   <= '0;
            done_out   <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        state    <= ST_LOAD;
                        idx      <= '0;
                        busy_out <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    step_out <= idx;
                    cnt      <= entry_dur;
                    // A zero-duration entry never reaches fcw_out; it is skipped below.
                    if (entry_dur != '0) begin
                        fcw_out    <= entry_fcw;
                        nco_en_out <= 1'b1;
                        state      <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick_in && (cnt != DUR_BITS'(1))) begin
                        cnt <= cnt - DUR_BITS'(1);
                    end
                end
                ST_GAP: begin
                    if (tick_in) begin
                        if (gap_cnt == GAP_CNT_BITS'(1)) begin
                            state <= ST_LOAD;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_CNT_BITS'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (entry_done) begin
                nco_en_out <= 1'b0;
                if (table_end) begin
                    if (loop_in) begin
                        idx   <= '0;
                        state <= ST_LOAD;
                    end else begin
                        state    <= ST_IDLE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        fcw_out  <= '0;
                    end
                end else begin
                    idx <= idx + ADDR_BITS'(1);
`ifdef TONE_GAP_EN
                    state   <= ST_GAP;
                    gap_cnt <= GAP_CNT_BITS'(GAP_TICKS);
`else
                    state   <= ST_LOAD;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_tone_seq_ctrl.sv
// tb/tb_tone_seq_ctrl.sv - directed self-checking bench for tone_seq_ctrl (gap suite when TONE_GAP_EN is defined)
module tb_tone_seq_ctrl;
    import tone_seq_pkg::*;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic                 start_in = 1'b0;
    logic                 stop_in = 1'b0;
    logic                 loop_in = 1'b0;
    logic                 tick_in = 1'b0;
    logic                 cfg_we_in = 1'b0;
    logic [ADDR_BITS-1:0] cfg_addr_in = '0;
    logic [FCW_BITS-1:0]  cfg_fcw_in = '0;
    logic [DUR_BITS-1:0]  cfg_dur_in = '0;
    logic                 cfg_last_in = 1'b0;
    logic [FCW_BITS-1:0]  fcw_out;
    logic                 nco_en_out;
    logic                 busy_out;
    logic [ADDR_BITS-1:0] step_out;
    logic                 done_out;

    int n_checks = 0;
    int n_fail   = 0;

    tone_seq_ctrl dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (start_in),
        .stop_in     (stop_in),
        .loop_in     (loop_in),
        .tick_in     (tick_in),
        .cfg_we_in   (cfg_we_in),
        .cfg_addr_in (cfg_addr_in),
        .cfg_fcw_in  (cfg_fcw_in),
        .cfg_dur_in  (cfg_dur_in),
        .cfg_last_in (cfg_last_in),
        .fcw_out     (fcw_out),
        .nco_en_out  (nco_en_out),
        .busy_out    (busy_out),
        .step_out    (step_out),
        .done_out    (done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input int a, input int f, input int d, input int l);
        cfg_we_in   = 1'b1;
        cfg_addr_in = ADDR_BITS'(a);
        cfg_fcw_in  = FCW_BITS'(f);
        cfg_dur_in  = DUR_BITS'(d);
        cfg_last_in = l[0];
        step();
        cfg_we_in = 1'b0;
    endtask

    task automatic kick();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    function automatic int outs();
        return int'({fcw_out, nco_en_out, busy_out, step_out, done_out});
    endfunction

    initial begin
        int done_cnt;
        int done_at;
        int en_cnt;
        int low_cnt;
        int seen;
        int busy_all;

        step();
        step();
        check("reset_outputs", outs(), 0);
        rst_in = 1'b0;

`ifndef TONE_GAP_EN
        // Two-entry table, tick every clk, no loop
        wr(0, 3, 2, 0);
        wr(1, 5, 1, 1);
        tick_in = 1'b1;
        kick();
        check("t2_load_busy", busy_out, 1);
        check("t2_load_en", nco_en_out, 0);
        step();
        check("t2_e0_fcw", fcw_out, 3);
        check("t2_e0_en", nco_en_out, 1);
        check("t2_e0_step", step_out, 0);
        step();
        check("t2_e0_fcw_b", fcw_out, 3);
        step();
        check("t2_reload_en", nco_en_out, 0);
        check("t2_reload_busy", busy_out, 1);
        step();
        check("t2_e1_fcw", fcw_out, 5);
        check("t2_e1_step", step_out, 1);
        check("t2_e1_en", nco_en_out, 1);
        step();
        check("t2_done", done_out, 1);
        check("t2_done_busy", busy_out, 0);
        check("t2_done_fcw", fcw_out, 0);
        check("t2_done_en", nco_en_out, 0);
        step();
        check("t2_done_pulse", done_out, 0);

        // Same table looping; stop aborts without done
        loop_in = 1'b1;
        kick();
        repeat (4) step();
        check("t3_e1_step", step_out, 1);
        check("t3_e1_fcw", fcw_out, 5);
        step();
        check("t3_wrap_en", nco_en_out, 0);
        check("t3_wrap_done", done_out, 0);
        step();
        check("t3_wrap_step", step_out, 0);
        check("t3_wrap_fcw", fcw_out, 3);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            done_cnt += int'(done_out);
        end
        check("t3_no_done", done_cnt, 0);
        check("t3_still_busy", busy_out, 1);
        stop_in = 1'b1;
        step();
        stop_in = 1'b0;
        check("t3_stop_outputs", outs(), 0);
        step();
        check("t3_stop_no_done", done_out, 0);

        // Reset mid-PLAY clears outputs and table
        loop_in = 1'b0;
        tick_in = 1'b0;
        kick();
        step();
        step();
        check("t1_pre_play", nco_en_out, 1);
        rst_in = 1'b1;
        step();
        check("t1_rst_outputs", outs(), 0);
        step();
        rst_in = 1'b0;

        // Cleared table: every entry skipped, end at idx DEPTH-1
        tick_in = 1'b1;
        kick();
        done_at = -1;
        seen = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (done_out && done_at < 0) done_at = i;
            seen |= int'(nco_en_out);
        end
        check("t_zero_done_at", done_at, 8);
        check("t_zero_no_en", seen, 0);

        loop_in = 1'b1;
        kick();
        seen = 0;
        busy_all = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            seen |= int'(nco_en_out);
            busy_all &= int'(busy_out);
        end
        check("t_zero_loop_en", seen, 0);
        check("t_zero_loop_busy", busy_all, 1);
        stop_in = 1'b1;
        step();
        stop_in = 1'b0;
        check("t_zero_loop_stop", busy_out, 0);
        loop_in = 1'b0;

        // Zero-duration entry 0 is skipped
        wr(0, 9, 0, 0);
        wr(1, 7, 3, 1);
        kick();
        step();
        check("t4_skip_fcw", fcw_out, 0);
        check("t4_skip_en", nco_en_out, 0);
        seen = 0;
        en_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (fcw_out == 4'd9) seen = 1;
            en_cnt += int'(nco_en_out);
            done_cnt += int'(done_out);
            if (i == 0) check("t4_e1_fcw", fcw_out, 7);
        end
        check("t4_never_fcw9", seen, 0);
        check("t4_en_cycles", en_cnt, 3);
        check("t4_done_cnt", done_cnt, 1);

        // Writes while busy are ignored
        loop_in = 1'b1;
        tick_in = 1'b0;
        kick();
        step();
        step();
        check("t5_busy_fcw", fcw_out, 7);
        wr(1, 2, 1, 1);
        wr(0, 2, 1, 0);
        stop_in = 1'b1;
        step();
        stop_in = 1'b0;
        loop_in = 1'b0;
        tick_in = 1'b1;
        kick();
        step();
        step();
        check("t5_unchanged_fcw", fcw_out, 7);
        check("t5_unchanged_en", nco_en_out, 1);
        repeat (3) step();
        check("t5_done", done_out, 1);

        // start with stop in the same clk stays idle
        start_in = 1'b1;
        stop_in  = 1'b1;
        step();
        start_in = 1'b0;
        stop_in  = 1'b0;
        check("t5_start_stop_busy", busy_out, 0);
        step();
        check("t5_start_stop_idle", busy_out, 0);

        // Write and start in the same clk: LOAD sees the new entry
        cfg_we_in   = 1'b1;
        cfg_addr_in = '0;
        cfg_fcw_in  = 4'd6;
        cfg_dur_in  = 16'd1;
        cfg_last_in = 1'b1;
        start_in    = 1'b1;
        step();
        cfg_we_in = 1'b0;
        start_in  = 1'b0;
        step();
        check("t5_wr_start_fcw", fcw_out, 6);
        step();
        check("t5_wr_start_done", done_out, 1);
`else
        // Gap between entries: GAP_TICKS silent ticks plus the LOAD clk, none at table end
        wr(0, 3, 2, 0);
        wr(1, 5, 1, 1);
        tick_in = 1'b1;
        kick();
        done_at = -1;
        low_cnt = 0;
        en_cnt  = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (done_out && done_at < 0) done_at = i;
            if (busy_out && !nco_en_out) low_cnt++;
            en_cnt += int'(nco_en_out);
            if (i == 4) check("t6_gap_fcw_held", fcw_out, 3);
            if (i == 8) check("t6_e1_fcw", fcw_out, 5);
        end
        check("t6_gap_low", low_cnt, GAP_TICKS + 1);
        check("t6_en_cycles", en_cnt, 3);
        check("t6_done_at", done_at, 9);
        check("t6_idle_end", busy_out, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
